inst_rom_loader: RTL

Instruction memory directly upstream of the MIPS core. It answers the core's fetch port (rom_addr_out/rom_enable in, rom_data_in out) with a combinational word read. It also contains a byte-stream boot loader FSM that writes a program image into the array. While loading, it holds the core in reset and drives NOPs.

---
 rtl/inst_rom_loader_pkg.sv | 17 +
 rtl/inst_rom_loader_rom_array.sv | 24 ++
 rtl/inst_rom_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared widths, the NOP word and the boot loader state encoding for the
// instruction ROM / loader slice.
package inst_rom_loader_pkg;

  localparam int unsigned INST_ADDR_WIDTH = 32;
  localparam int unsigned INST_DATA_WIDTH = 32;

  // All-zero word is "sll $0,$0,0", i.e. a MIPS NOP.
  localparam logic [INST_DATA_WIDTH-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_LOAD = 2'd1,
    LDR_DONE = 2'd2
  } ldr_state_t;

endpackage

// File: rtl/inst_rom_loader_rom_array.sv
// Instruction word storage: one synchronous write port, one asynchronous
// read port, so it maps onto distributed RAM. Contents are never reset.
module rom_array #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  // Write port: one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory in front of the MIPS core, with a byte-stream boot
// loader that writes a program image and holds the core in reset meanwhile.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = INST_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = INST_DATA_WIDTH,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned BOOT_HOLD  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rom_addr_in,
  input  logic                  rom_enable_in,
  output logic [DATA_WIDTH-1:0] rom_data_out,
  input  logic                  load_start,
  input  logic [DEPTH_LOG2:0]   load_count,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_ready,
  output logic                  core_rst_n_out,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic             HOLD   = (BOOT_HOLD != 0);
  localparam logic [DEPTH_LOG2:0] WA_ONE = 1;

  ldr_state_t            state, state_nxt;
  logic [1:0]            byte_cnt;
  logic [DEPTH_LOG2:0]   word_addr;
  logic [DEPTH_LOG2:0]   count_q;
  logic [23:0]           asm_q;
  logic                  boot_ok;
  logic                  load_done_q;
  logic                  load_err_q;

  logic                  count_ok;
  logic                  start_ok;
  logic                  start_bad;
  logic                  wr_en;
  logic                  last_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_addr_bits;

  // Accept 1..2^DEPTH_LOG2: nonzero, and if the MSB is set the rest must be 0.
  assign count_ok = (|load_count) &&
                    (!load_count[DEPTH_LOG2] || (load_count[DEPTH_LOG2-1:0] == '0));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LDR_IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake, core reset and write strobe.
  always_comb begin
    state_nxt      = state;
    load_ready     = 1'b0;
    core_rst_n_out = !HOLD || boot_ok;
    start_ok       = 1'b0;
    start_bad      = 1'b0;
    wr_en          = 1'b0;
    last_word      = 1'b0;
    case (state)
      LDR_LOAD: begin
        load_ready     = 1'b1;
        core_rst_n_out = 1'b0;
        if (load_valid && (byte_cnt == 2'd3)) begin
          wr_en     = 1'b1;
          last_word = ((word_addr + WA_ONE) == count_q);
          if (last_word) state_nxt = LDR_DONE;
        end
      end
      default: begin
        if (state == LDR_DONE) core_rst_n_out = 1'b1;
        if (load_start) begin
          if (count_ok) begin
            start_ok  = 1'b1;
            state_nxt = LDR_LOAD;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
    endcase
  end

  // Loader datapath: count latch, byte assembly, word address, status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt    <= '0;
      word_addr   <= '0;
      count_q     <= '0;
      asm_q       <= '0;
      boot_ok     <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      load_done_q <= wr_en && last_word;
      if (wr_en && last_word) boot_ok <= 1'b1;
      if (start_ok) begin
        count_q    <= load_count;
        byte_cnt   <= '0;
        word_addr  <= '0;
        load_err_q <= 1'b0;
      end else if (start_bad) begin
        load_err_q <= 1'b1;
      end
      if (load_ready && load_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_q    <= {asm_q[15:0], load_byte};
        if (wr_en) word_addr <= word_addr + WA_ONE;
      end
    end
  end

  assign load_done = load_done_q;
  assign load_err  = load_err_q;

  rom_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rom_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (word_addr[DEPTH_LOG2-1:0]),
    .wdata ({asm_q, load_byte}),
    .raddr (rom_addr_in[DEPTH_LOG2+1:2]),
    .rdata (rd_data)
  );

  // Byte offset within a word is irrelevant to word fetches.
  assign unused_addr_bits = ^rom_addr_in[1:0];

  // Fetch gating: NOP when disabled, loading, or above the array.
  always_comb begin
    rom_data_out = NOP_WORD;
    if (rom_enable_in && (state != LDR_LOAD) &&
        (rom_addr_in[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0))
      rom_data_out = rd_data;
  end

endmodule
